// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for nibble_serial_adder
//
// Signals:
//   in_valid/in_ready    operand handshake (master -> slave)
//   in_a, in_b, in_cin   operands and carry-in
//   out_valid/out_ready  result handshake (slave -> master)
//   out_sum, out_cout    WIDTH-bit sum and carry out of the MSB nibble
//   out_ovf              signed overflow of the addition
//   busy                 adder is working on or holding a result
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - sequential WIDTH-bit adder, one nibble per cycle
//
// fourbitadd: combinational 4-bit adder slice.
//   fa, fb  nibble operands; fcin carry-in; fy nibble sum; fcout carry-out.
//
// nibble_serial_adder: accepts operands in IDLE, feeds one nibble per cycle
// (LSB first) through fourbitadd with the carry held in a register, then
// presents the result until the consumer takes it.
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    nibble_serial_adder_if.slave (operand/result handshakes, busy)
module fourbitadd (
    input  logic [3:0] fa,
    input  logic [3:0] fb,
    input  logic       fcin,
    output logic [3:0] fy,
    output logic       fcout
);
    assign {fcout, fy} = {1'b0, fa} + {1'b0, fb} + {4'b0000, fcin};
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [3:0]       w_fa;
    logic [3:0]       w_fb;
    logic [3:0]       w_fy;
    logic             w_fcout;

    // Current nibble selected by shifting the latched operands down by 4*count.
    assign w_a_shift = r_a >> {r_count, 2'b00};
    assign w_b_shift = r_b >> {r_count, 2'b00};
    assign w_fa      = w_a_shift[3:0];
    assign w_fb      = w_b_shift[3:0];

    fourbitadd u_add (
        .fa    (w_fa),
        .fb    (w_fb),
        .fcin  (r_carry),
        .fy    (w_fy),
        .fcout (w_fcout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b;
                        r_carry <= bus.in_cin;
                        r_count <= '0;
                        r_sum   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (r_count == CW'(n)) begin
                            r_sum[4*n +: 4] <= w_fy;
                        end
                    end
                    r_carry <= w_fcout;
                    if (r_count == LAST) begin
                        r_cout  <= w_fcout;
                        // Carry into the MSB bit is recovered from the sum bit:
                        // cin_msb = a ^ b ^ y; overflow when it differs from cout.
                        r_ovf   <= w_fcout ^ (w_fa[3] ^ w_fb[3] ^ w_fy[3]);
                        r_count <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Drives one operation. mode: 0 = leave result pending, 1 = take at once,
    // 2 = take with random out_ready. Returns latency from accept edge to
    // out_valid, out_sum seen right after accept, and the presented result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int mode, output int lat, output logic [15:0] sum_acc,
                          output logic [15:0] sum, output logic cout, output logic ovf,
                          output bit timed_out);
        int n;
        timed_out = 1'b0;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_cin = cin;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (bus.in_ready !== 1'b1) timed_out = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sum_acc = bus.out_sum;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (bus.out_valid !== 1'b1) timed_out = 1'b1;
        sum = bus.out_sum;
        cout = bus.out_cout;
        ovf = bus.out_ovf;
        if (mode == 1) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end else if (mode == 2) begin
            n = 0;
            do begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1; n++;
            end while (bus.out_valid === 1'b1 && n < 100);
            bus.out_ready = 1'b0;
            if (bus.out_valid !== 1'b0) timed_out = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if ({bus.out_sum, bus.out_cout, bus.out_ovf} !== 18'h0) begin failures++; $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b expected 0/0/0", bus.out_sum, bus.out_cout, bus.out_ovf); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [15:0] va [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
        logic [15:0] vb [3] = '{16'h4321, 16'h0001, 16'h0000};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] es [3] = '{16'h5555, 16'h0000, 16'h8000};
        logic        ec [3] = '{1'b0, 1'b1, 1'b0};
        logic        eo [3] = '{1'b0, 1'b0, 1'b1};
        int lat; logic [15:0] sacc, s; logic c, o; bit to;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], 1, lat, sacc, s, c, o, to);
            checks++; if (to) begin failures++; $display("FAIL vec%0d_timeout: handshake did not complete", i); end
            checks++; if (lat != 4) begin failures++; $display("FAIL vec%0d_latency: got %0d expected 4", i, lat); end
            checks++; if (sacc !== 16'h0000) begin failures++; $display("FAIL vec%0d_sum_cleared: got %h expected 0000", i, sacc); end
            checks++; if (s !== es[i]) begin failures++; $display("FAIL vec%0d_sum: got %h expected %h", i, s, es[i]); end
            checks++; if (c !== ec[i]) begin failures++; $display("FAIL vec%0d_cout: got %b expected %b", i, c, ec[i]); end
            checks++; if (o !== eo[i]) begin failures++; $display("FAIL vec%0d_ovf: got %b expected %b", i, o, eo[i]); end
            checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL vec%0d_idle_after: in_ready=%b busy=%b expected 1/0", i, bus.in_ready, bus.busy); end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [15:0] sacc, s; logic c, o; bit to;
        // 0x8000 + 0x8000: sum 0, carry out, two negatives give a positive.
        run_op(16'h8000, 16'h8000, 1'b0, 0, lat, sacc, s, c, o, to);
        checks++; if (to) begin failures++; $display("FAIL bp_timeout: out_valid never rose"); end
        checks++; if ({s, c, o} !== {16'h0000, 1'b1, 1'b1}) begin failures++; $display("FAIL bp_result: got sum=%h cout=%b ovf=%b expected 0000/1/1", s, c, o); end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_a = 16'hAAAA;
            bus.in_b = 16'h5555;
            bus.in_cin = 1'b1;
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL bp_hold%0d_ctrl: out_valid=%b in_ready=%b busy=%b expected 1/0/1", i, bus.out_valid, bus.in_ready, bus.busy); end
            checks++; if ({bus.out_sum, bus.out_cout, bus.out_ovf} !== {16'h0000, 1'b1, 1'b1}) begin failures++; $display("FAIL bp_hold%0d_data: got sum=%h cout=%b ovf=%b expected 0000/1/1", i, bus.out_sum, bus.out_cout, bus.out_ovf); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready); end
        checks++; if ({bus.out_sum, bus.out_cout, bus.out_ovf} !== {16'h0000, 1'b1, 1'b1}) begin failures++; $display("FAIL bp_keep_last: got sum=%h cout=%b ovf=%b expected 0000/1/1", bus.out_sum, bus.out_cout, bus.out_ovf); end
        // out_ready in IDLE has no effect; block stays idle with nothing offered.
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle_stays: busy=%b out_valid=%b expected 0/0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [15:0] sacc, s; logic c, o; bit to;
        bus.in_a = 16'hFFFF;
        bus.in_b = 16'hFFFF;
        bus.in_cin = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1 || bus.out_sum !== 16'h00FF) begin failures++; $display("FAIL rst_partial: busy=%b sum=%h expected 1/00ff", bus.busy, bus.out_sum); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_ctrl: in_ready=%b out_valid=%b busy=%b expected 1/0/0", bus.in_ready, bus.out_valid, bus.busy); end
        checks++; if (bus.out_sum !== 16'h0000) begin failures++; $display("FAIL rst_mid_sum: got %h expected 0000", bus.out_sum); end
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1, lat, sacc, s, c, o, to);
        checks++; if (to || lat != 4) begin failures++; $display("FAIL rst_new_op_timing: timeout=%0d latency=%0d expected 0/4", to, lat); end
        checks++; if ({s, c, o} !== {16'h1000, 1'b0, 1'b0}) begin failures++; $display("FAIL rst_new_op_result: got sum=%h cout=%b ovf=%b expected 1000/0/0", s, c, o); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] sacc, s; logic c, o; bit to;
        logic [15:0] a, b; logic cin;
        logic [16:0] full;
        logic eovf;
        int bad = 0;
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            full = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
            eovf = (a[15] == b[15]) && (full[15] != a[15]);
            run_op(a, b, cin, 2, lat, sacc, s, c, o, to);
            checks++;
            if (to || lat != 4 || {c, s} !== full || o !== eovf) begin
                failures++;
                bad++;
                if (bad <= 10) $display("FAIL b2b_%0d: a=%h b=%h cin=%b got cout=%b sum=%h ovf=%b lat=%0d to=%0d expected %b/%h/%b lat 4", i, a, b, cin, c, s, o, lat, to, full[16], full[15:0], eovf);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_cin = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
